// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential IEEE 754 single-precision divider, radix-2 restoring, one quotient bit per clock
// ports: clk, rst_n (async active-low); in_valid/in_ready with operands a (dividend), b (divisor);
//        out_valid/out_ready with res (quotient) and flags {overflow, underflow, div_by_zero}
module fp_divider_seq #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic [2:0]  flags
);
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  state_t state_q, state_d;
  logic sign_q, sign_d;
  logic [23:0] op_b_q, op_b_d;
  logic [25:0] r_q, r_d, q_q, q_d;
  logic [4:0] count_q, count_d;
  logic [7:0] ea_q, ea_d, eb_q, eb_d;
  logic [31:0] res_q, res_d;
  logic [2:0] flags_q, flags_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic s, a_inf, b_inf, a_zero, b_zero, special, ge, guard, sticky, ovf, unf;
  logic [25:0] diff;
  logic [22:0] mant, mant_r;
  logic [9:0] e;
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    op_b_d = op_b_q;
    r_d = r_q;
    q_d = q_q;
    count_d = count_q;
    ea_d = ea_q;
    eb_d = eb_q;
    res_d = res_q;
    flags_d = flags_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    s = a[31] ^ b[31];
    a_inf = a[30:23] == 8'hFF;
    b_inf = b[30:23] == 8'hFF;
    a_zero = a[30:23] == 8'h00;
    b_zero = b[30:23] == 8'h00;
    special = a_inf | b_inf | a_zero | b_zero;
    ge = r_q >= {2'b0, op_b_q};
    diff = ge ? r_q - {2'b0, op_b_q} : r_q;
    // q[25] set means the mantissa ratio is >= 1; otherwise normalise one place left
    mant = q_q[25] ? q_q[24:2] : q_q[23:1];
    guard = q_q[25] ? q_q[1] : q_q[0];
    sticky = (q_q[25] & q_q[0]) | (r_q != '0);
    mant_r = mant + {22'd0, ROUND_EN & guard & sticky};
    e = {2'b0, ea_q} - {2'b0, eb_q} + (q_q[25] ? 10'd127 : 10'd126);
    ovf = $signed(e) > 10'sd254;
    unf = $signed(e) < 10'sd1;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d = s;
        r_d = {2'b0, ~a_zero, a[22:0]};
        op_b_d = {~b_zero, b[22:0]};
        ea_d = a[30:23];
        eb_d = b[30:23];
        q_d = '0;
        count_d = '0;
        in_ready_d = 1'b0;
        out_valid_d = special;
        state_d = special ? DONE : DIV;
        if (special) begin
          res_d = (a_inf | b_inf) ? 32'h0 : b_zero ? {s, 8'hFF, 23'd0} : {s, 31'd0};
          flags_d = {2'b00, ~(a_inf | b_inf) & b_zero};
        end
      end
      DIV: begin
        r_d = {diff[24:0], 1'b0};
        q_d = {q_q[24:0], ge};
        count_d = count_q + 5'd1;
        state_d = count_q == 5'd25 ? NORM : DIV;
      end
      NORM: begin
        res_d = ovf ? {sign_q, 8'hFF, 23'd0} : unf ? {sign_q, 31'd0} : {sign_q, e[7:0], mant_r};
        flags_d = {ovf, unf, 1'b0};
        out_valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      op_b_q <= '0;
      r_q <= '0;
      q_q <= '0;
      count_q <= '0;
      ea_q <= '0;
      eb_q <= '0;
      res_q <= '0;
      flags_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      op_b_q <= op_b_d;
      r_q <= r_d;
      q_q <= q_d;
      count_q <= count_d;
      ea_q <= ea_d;
      eb_q <= eb_d;
      res_q <= res_d;
      flags_q <= flags_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign res = res_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq: self-checking bench for fp_divider_seq (rounded and truncating instances side by side)
module tb_fp_divider_seq;
  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  logic [31:0] a, b;
  logic in_ready, out_valid, in_ready_t, out_valid_t;
  logic [31:0] res, res_t;
  logic [2:0] flags, flags_t;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fp_divider_seq #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .flags(flags)
  );
  fp_divider_seq #(.ROUND_EN(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .a(a), .b(b),
    .out_valid(out_valid_t), .out_ready(out_ready), .res(res_t), .flags(flags_t)
  );
  typedef struct {
    logic [31:0] a, b, res, res_t;
    logic [2:0] flags;
    int lat;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  // reference: exact integer division of the significands, then IEEE-style normalise/round
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input bit rnd);
    logic s;
    logic [63:0] num, den, qq, rem;
    logic [22:0] m;
    bit g, st;
    int e;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return 35'd0;
    if (y[30:23] == 8'h00) return {3'b001, s, 8'hFF, 23'd0};
    if (x[30:23] == 8'h00) return {3'b000, s, 31'd0};
    num = {40'd0, 1'b1, x[22:0]} << 25;
    den = {40'd0, 1'b1, y[22:0]};
    qq = num / den;
    rem = num % den;
    e = int'(x[30:23]) - int'(y[30:23]) + (qq[25] ? 127 : 126);
    m = qq[25] ? qq[24:2] : qq[23:1];
    g = qq[25] ? qq[1] : qq[0];
    st = (qq[25] && qq[0]) || rem != 0;
    m = m + 23'(rnd && g && st);
    if (e >= 255) return {3'b100, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b010, s, 31'd0};
    return {3'b000, s, 8'(e), m};
  endfunction
  function automatic logic [31:0] rnd_fp();
    int k;
    logic [7:0] ex;
    k = $urandom_range(0, 11);
    ex = k == 0 ? 8'h00 : k == 1 ? 8'hFF : 8'($urandom_range(1, 254));
    return {1'($urandom), ex, 23'($urandom)};
  endfunction
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_result(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_valid_timeout: got 0 expected 1 within 60 cycles");
    end
    chk("out_valid_pair", {31'd0, out_valid_t}, {31'd0, out_valid});
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  initial begin
    int cyc, lat;
    logic [31:0] x, y, r0;
    logic [34:0] e1, e0;
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 3'b000, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 3'b000, 28};
    vecs[2]  = '{32'h40000000, 32'h00000000, 32'h7F800000, 32'h7F800000, 3'b001, 1};
    vecs[3]  = '{32'h7F800000, 32'h40000000, 32'h00000000, 32'h00000000, 3'b000, 1};
    vecs[4]  = '{32'h00000000, 32'h40000000, 32'h00000000, 32'h00000000, 3'b000, 1};
    vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, 3'b100, 28};
    vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, 3'b010, 28};
    vecs[7]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 3'b000, 28};
    vecs[8]  = '{32'h40000000, 32'h7FC00000, 32'h00000000, 32'h00000000, 3'b000, 1};
    vecs[9]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 32'hFF800000, 3'b001, 1};
    vecs[10] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 32'h7F800000, 3'b001, 1};
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_flags", {29'd0, flags}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_result(cyc);
      chk($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
      chk($sformatf("vec%0d_res", i), res, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), {29'd0, flags}, {29'd0, vecs[i].flags});
      chk($sformatf("vec%0d_res_trunc", i), res_t, vecs[i].res_t);
      chk($sformatf("vec%0d_flags_trunc", i), {29'd0, flags_t}, {29'd0, vecs[i].flags});
      consume();
    end
    issue(32'h40C00000, 32'h40000000);
    wait_result(cyc);
    a = 32'h3F800000;
    b = 32'h40400000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_res", res, 32'h40400000);
      chk("hold_flags", {29'd0, flags}, 32'd0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    consume();
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    issue(32'h3F800000, 32'h40400000);
    wait_result(cyc);
    chk("b2b_latency", cyc, 28);
    chk("b2b_res", res, 32'h3EAAAAAB);
    chk("b2b_res_trunc", res_t, 32'h3EAAAAAA);
    consume();
    issue(32'h40C00000, 32'h40000000);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_res", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    issue(32'h40C00000, 32'h40000000);
    wait_result(cyc);
    chk("after_abort_latency", cyc, 28);
    chk("after_abort_res", res, 32'h40400000);
    consume();
    for (int i = 0; i < 150; i++) begin
      x = rnd_fp();
      y = rnd_fp();
      e1 = model(x, y, 1'b1);
      e0 = model(x, y, 1'b0);
      lat = (x[30:23] == 8'hFF || y[30:23] == 8'hFF || x[30:23] == 8'h00 || y[30:23] == 8'h00) ? 1 : 28;
      issue(x, y);
      wait_result(cyc);
      r0 = res;
      chk($sformatf("rand%0d_latency a=%h b=%h", i, x, y), cyc, lat);
      chk($sformatf("rand%0d_res a=%h b=%h", i, x, y), r0, e1[31:0]);
      chk($sformatf("rand%0d_flags a=%h b=%h", i, x, y), {29'd0, flags}, {29'd0, e1[34:32]});
      chk($sformatf("rand%0d_res_trunc a=%h b=%h", i, x, y), res_t, e0[31:0]);
      chk($sformatf("rand%0d_flags_trunc a=%h b=%h", i, x, y), {29'd0, flags_t}, {29'd0, e0[34:32]});
      consume();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
